// File: rtl/jtopl_mmr_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : jtopl_mmr_q                                                       |
// | Queued register front-end for JTOPL (OPL/OPL2/OPL3). CPU writes land at    |
// | bus speed; data writes are buffered in a FIFO and drained towards the      |
// | register file no closer than GAP cen ticks apart, each drain decoded into  |
// | slot/channel selectors and one-cycle update strobes.                       |
// |                                                                            |
// | Ports                                                                      |
// |   clk, rst_n (async, active-low), cen (chip clock enable)                  |
// |   write, addr[1:0] (bit0 data/address, bit1 bank), din[7:0], ovf_clr       |
// |   full, busy, ovf          : queue status (registered)                     |
// |   wr_stb, wr_bank, wr_reg, wr_data : drained entry                         |
// |   sel_group, sel_sub, sel_ch        : decoded location                     |
// |   up_*                              : per-register update strobes          |
// |   wave_mode, opl3_en                : latched mode bits                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module jtopl_mmr_q #(
  parameter int OPL_TYPE = 1,
  parameter int DEPTH    = 8,
  parameter int GAP      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       write,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       ovf_clr,
  output logic       full,
  output logic       busy,
  output logic       ovf,
  output logic       wr_stb,
  output logic       wr_bank,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic [4:0] sel_ch,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_fbcon,
  output logic       up_glb,
  output logic       up_ctl,
  output logic       up_conn,
  output logic       wave_mode,
  output logic       opl3_en
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] GAP_LD = 4'(GAP - 1);

  // Entry layout: {bank, reg[7:0], data[7:0]}
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nx;
  logic [3:0]    gcnt, gcnt_nx;
  logic [7:0]    selreg;
  logic          selbank;

  logic          pop, push_req, push, drop;
  logic          e_bank;
  logic [7:0]    e_reg, e_data;

  assign pop      = cen & (gcnt == 4'd0) & (count != '0);
  assign push_req = write & addr[0];
  // A full queue still accepts when the head leaves in the same cycle.
  assign push     = push_req & ((count != (AW+1)'(DEPTH)) | pop);
  assign drop     = push_req & ~push;
  assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    gcnt_nx = gcnt;
    if (pop)                       gcnt_nx = GAP_LD;
    else if (cen && gcnt != 4'd0)  gcnt_nx = gcnt - 4'd1;
  end

  assign {e_bank, e_reg, e_data} = mem[rptr];

  // Storage is not reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {selbank, selreg, din};
  end

  // ---------------------------------------------------------------- decode
  // dec bit order: mult, ksl_tl, ar_dr, sl_rr, wav, fnumlo, fnumhi, fbcon,
  //                glb, ctl, conn
  logic [10:0] dec;
  logic        hit_op, hit_ch, wav_ok;
  logic [1:0]  n_grp;
  logic [2:0]  n_sub;
  logic [4:0]  n_ch;

  assign wav_ok = ((OPL_TYPE == 2) && wave_mode) ||
                  ((OPL_TYPE == 3) && (wave_mode || opl3_en));

  always_comb begin
    dec    = '0;
    n_grp  = sel_group;
    n_sub  = sel_sub;
    n_ch   = sel_ch;
    hit_op = ((e_reg >= 8'h20 && e_reg <= 8'h9F) ||
              (OPL_TYPE > 1 && e_reg >= 8'hE0 && e_reg <= 8'hF5)) &&
             (e_reg[2:0] <= 3'd5) && (e_reg[4:3] != 2'b11);
    hit_ch = (e_reg[7:4] >= 4'hA) && (e_reg[7:4] <= 4'hC) && (e_reg[3:0] <= 4'd8);
    if (hit_op) begin
      n_grp = e_reg[4:3];
      n_sub = e_reg[2:0];
      case (e_reg[7:5])
        3'd1:    dec[10] = 1'b1;
        3'd2:    dec[9]  = 1'b1;
        3'd3:    dec[8]  = 1'b1;
        3'd4:    dec[7]  = 1'b1;
        3'd7:    dec[6]  = wav_ok;
        default: ;
      endcase
    end
    if (hit_ch) begin
      n_ch = {1'b0, e_reg[3:0]} + (e_bank ? 5'd9 : 5'd0);
      n_grp = (e_reg[3:0] < 4'd3) ? 2'd0 : (e_reg[3:0] < 4'd6) ? 2'd1 : 2'd2;
      // Channels 6..8 fold back onto sub-indices 0..2 of the third group.
      n_sub = (e_reg[3:0] < 4'd6) ? e_reg[2:0] : {1'b0, ~&e_reg[2:1], e_reg[0]};
      case (e_reg[7:4])
        4'hA:    dec[5] = 1'b1;
        4'hB:    dec[4] = 1'b1;
        4'hC:    dec[3] = 1'b1;
        default: ;
      endcase
    end
    dec[2] = !e_bank && (e_reg == 8'hBD);
    dec[1] = !e_bank && (e_reg >= 8'h01) && (e_reg <= 8'h08);
    dec[0] = (OPL_TYPE == 3) && e_bank && (e_reg == 8'h04);
  end

  logic [10:0] up_q;
  assign {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo,
          up_fnumhi, up_fbcon, up_glb, up_ctl, up_conn} = up_q;

  // ------------------------------------------------------------ sequential
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      gcnt      <= '0;
      selreg    <= '0;
      selbank   <= 1'b0;
      full      <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
      wr_stb    <= 1'b0;
      wr_bank   <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
      sel_group <= '0;
      sel_sub   <= '0;
      sel_ch    <= '0;
      up_q      <= '0;
      wave_mode <= 1'b0;
      opl3_en   <= 1'b0;
    end else begin
      if (write && !addr[0]) begin
        selreg  <= din;
        selbank <= (OPL_TYPE == 3) ? addr[1] : 1'b0;
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count_nx;
      gcnt  <= gcnt_nx;
      full  <= (count_nx == (AW+1)'(DEPTH));
      busy  <= (count_nx != '0) || (gcnt_nx != 4'd0);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      wr_stb <= pop;
      up_q   <= pop ? dec : 11'd0;
      if (pop) begin
        wr_bank <= e_bank;
        wr_reg  <= e_reg;
        wr_data <= e_data;
        if (hit_op || hit_ch) begin
          sel_group <= n_grp;
          sel_sub   <= n_sub;
          sel_ch    <= n_ch;
        end
        if (OPL_TYPE > 1 && !e_bank && e_reg == 8'h01) wave_mode <= e_data[5];
        if (OPL_TYPE == 3 && e_bank && e_reg == 8'h05) opl3_en <= e_data[0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtopl_mmr_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_jtopl_mmr_q                                                    |
// | Bench for jtopl_mmr_q: an OPL3 and an OPL instance share one stimulus      |
// | stream and are compared every cycle against a queue-based model.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_jtopl_mmr_q;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0, write = 1'b0, ovf_clr = 1'b0;
  logic [1:0] addr = '0;
  logic [7:0] din = '0;

  always #5 clk = ~clk;

  // DUT outputs, index 0 = OPL3 instance, index 1 = OPL instance
  logic       full [2], busy [2], ovf [2], stb [2], bank [2], wmode [2], o3en [2];
  logic [7:0] rreg [2], rdat [2];
  logic [1:0] grp [2];
  logic [2:0] sub [2];
  logic [4:0] ch [2];
  logic [10:0] up [2];

  jtopl_mmr_q #(.OPL_TYPE(3), .DEPTH(DEPTH), .GAP(GAP)) u_opl3 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .write(write), .addr(addr), .din(din),
    .ovf_clr(ovf_clr), .full(full[0]), .busy(busy[0]), .ovf(ovf[0]),
    .wr_stb(stb[0]), .wr_bank(bank[0]), .wr_reg(rreg[0]), .wr_data(rdat[0]),
    .sel_group(grp[0]), .sel_sub(sub[0]), .sel_ch(ch[0]),
    .up_mult(up[0][10]), .up_ksl_tl(up[0][9]), .up_ar_dr(up[0][8]), .up_sl_rr(up[0][7]),
    .up_wav(up[0][6]), .up_fnumlo(up[0][5]), .up_fnumhi(up[0][4]), .up_fbcon(up[0][3]),
    .up_glb(up[0][2]), .up_ctl(up[0][1]), .up_conn(up[0][0]),
    .wave_mode(wmode[0]), .opl3_en(o3en[0]));

  jtopl_mmr_q #(.OPL_TYPE(1), .DEPTH(DEPTH), .GAP(GAP)) u_opl1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .write(write), .addr(addr), .din(din),
    .ovf_clr(ovf_clr), .full(full[1]), .busy(busy[1]), .ovf(ovf[1]),
    .wr_stb(stb[1]), .wr_bank(bank[1]), .wr_reg(rreg[1]), .wr_data(rdat[1]),
    .sel_group(grp[1]), .sel_sub(sub[1]), .sel_ch(ch[1]),
    .up_mult(up[1][10]), .up_ksl_tl(up[1][9]), .up_ar_dr(up[1][8]), .up_sl_rr(up[1][7]),
    .up_wav(up[1][6]), .up_fnumlo(up[1][5]), .up_fnumhi(up[1][4]), .up_fbcon(up[1][3]),
    .up_glb(up[1][2]), .up_ctl(up[1][1]), .up_conn(up[1][0]),
    .wave_mode(wmode[1]), .opl3_en(o3en[1]));

  // ---------------------------------------------------------------- checker
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ------------------------------------------------------------------ model
  int          otype [2] = '{3, 1};
  logic [16:0] q [$];
  int          m_gcnt;
  logic        m_ovf, m_sbank, m_stb;
  logic [7:0]  m_sreg;
  logic        m_bank [2], m_wave [2], m_o3 [2];
  logic [7:0]  m_reg [2], m_data [2];
  int          m_grp [2], m_sub [2], m_ch [2];
  logic [10:0] m_up [2];

  task automatic model_reset();
    q.delete();
    m_gcnt = 0; m_ovf = 0; m_sbank = 0; m_sreg = 0; m_stb = 0;
    for (int i = 0; i < 2; i++) begin
      m_bank[i] = 0; m_wave[i] = 0; m_o3[i] = 0; m_reg[i] = 0; m_data[i] = 0;
      m_grp[i] = 0; m_sub[i] = 0; m_ch[i] = 0; m_up[i] = 0;
    end
  endtask

  // Register semantics from the register map, in plain arithmetic.
  task automatic model_decode(input int i, input logic [16:0] e);
    int t, b, r, d, lo;
    logic mult, ksl, ar, sl, wav, flo, fhi, fb, glb, ctl, conn;
    t = otype[i];
    b = (t == 3) ? int'(e[16]) : 0;
    r = int'(e[15:8]);
    d = int'(e[7:0]);
    {mult, ksl, ar, sl, wav, flo, fhi, fb, glb, ctl, conn} = '0;
    if (((r >= 32 && r < 160) || (t > 1 && r >= 224 && r <= 245)) &&
        (r % 8) <= 5 && ((r % 32) / 8) != 3) begin
      m_grp[i] = (r % 32) / 8;
      m_sub[i] = r % 8;
      case (r / 32)
        1: mult = 1;
        2: ksl = 1;
        3: ar = 1;
        4: sl = 1;
        7: wav = (t == 2 && m_wave[i]) || (t == 3 && (m_wave[i] || m_o3[i]));
        default: ;
      endcase
    end
    if (r / 16 >= 10 && r / 16 <= 12 && (r % 16) <= 8) begin
      lo = r % 16;
      m_ch[i]  = lo + 9 * b;
      m_grp[i] = lo / 3;
      m_sub[i] = (lo < 6) ? lo : lo - 6;
      flo = (r / 16 == 10);
      fhi = (r / 16 == 11);
      fb  = (r / 16 == 12);
    end
    glb  = (b == 0 && r == 'hBD);
    ctl  = (b == 0 && r >= 1 && r <= 8);
    conn = (t == 3 && b == 1 && r == 4);
    if (t > 1 && b == 0 && r == 1) m_wave[i] = d[5];
    if (t == 3 && b == 1 && r == 5) m_o3[i] = d[0];
    m_bank[i] = b[0];
    m_reg[i]  = r[7:0];
    m_data[i] = d[7:0];
    m_up[i]   = {mult, ksl, ar, sl, wav, flo, fhi, fb, glb, ctl, conn};
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [7:0] d,
                            input logic c, input logic clr);
    logic [16:0] e;
    logic        dropped;
    dropped = 0;
    m_stb = 0;
    m_up[0] = 0; m_up[1] = 0;
    if (c && m_gcnt == 0 && q.size() != 0) begin
      e = q.pop_front();
      m_stb = 1;
      model_decode(0, e);
      model_decode(1, e);
      m_gcnt = GAP - 1;
    end else if (c && m_gcnt != 0) begin
      m_gcnt--;
    end
    if (w && a[0]) begin
      if (q.size() < DEPTH) q.push_back({m_sbank, m_sreg, d});
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (w && !a[0]) begin
      m_sreg  = d;
      m_sbank = a[1];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("status%0d", otype[i]), {full[i], busy[i], ovf[i]},
          {(q.size() == DEPTH), (q.size() != 0 || m_gcnt != 0), m_ovf});
      chk($sformatf("entry%0d", otype[i]), {stb[i], bank[i], rreg[i], rdat[i]},
          {m_stb, m_bank[i], m_reg[i], m_data[i]});
      chk($sformatf("sel%0d", otype[i]), {grp[i], sub[i], ch[i]},
          {m_grp[i][1:0], m_sub[i][2:0], m_ch[i][4:0]});
      chk($sformatf("up%0d", otype[i]), up[i], m_up[i]);
      chk($sformatf("mode%0d", otype[i]), {wmode[i], o3en[i]}, {m_wave[i], m_o3[i]});
    end
  endtask

  // -------------------------------------------------------------- stimulus
  int          cyc = 0;
  int          cen_mode = 0;   // 0 low, 1 every 2 clk, 2 random
  int          drains [2] = '{0, 0};
  logic [10:0] last_up [2];
  logic [10:0] up_acc1 = '0;
  logic [7:0]  last_reg0, last_dat0;

  function automatic logic next_cen();
    case (cen_mode)
      1:       return (cyc % 2) == 0;
      2:       return ($urandom % 3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic c, input logic clr);
    write = w; addr = a; din = d; cen = c; ovf_clr = clr;
    @(posedge clk);
    cyc++;
    model_edge(w, a, d, c, clr);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (stb[i]) begin
        drains[i]++;
        last_up[i] = up[i];
      end
    end
    if (stb[0]) begin
      last_reg0 = rreg[0];
      last_dat0 = rdat[0];
    end
    up_acc1 |= up[1];
    compare_all();
  endtask

  task automatic wr_sel(input logic b, input logic [7:0] r);
    step(1'b1, {b, 1'b0}, r, next_cen(), 1'b0);
  endtask

  task automatic wr_dat(input logic [7:0] d);
    step(1'b1, 2'b01, d, next_cen(), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, 8'h00, next_cen(), 1'b0);
  endtask

  logic [7:0] picks [12] = '{8'h01, 8'h04, 8'h05, 8'hBD, 8'hE0, 8'hF5,
                             8'hA8, 8'hC9, 8'hB3, 8'h35, 8'h9D, 8'h08};

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Single write, cen every other clock
    cen_mode = 1;
    wr_sel(1'b0, 8'h20);
    wr_dat(8'h21);
    idle(20);
    chk("t1_drains", drains[0], 1);
    chk("t1_reg", last_reg0, 8'h20);
    chk("t1_data", last_dat0, 8'h21);
    chk("t1_up", last_up[0], 11'b100_0000_0000);

    // Fill past capacity with cen held low, then drain
    cen_mode = 0;
    wr_sel(1'b0, 8'h40);
    for (int k = 0; k < 8; k++) wr_dat(8'(k + 8'h10));
    chk("t2_full", full[0], 1'b1);
    chk("t2_ovf_before", ovf[0], 1'b0);
    wr_dat(8'hEE);
    chk("t2_ovf_after", ovf[0], 1'b1);
    drains[0] = 0;
    cen_mode = 1;
    idle(80);
    chk("t2_drains", drains[0], 8);
    step(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf_clr", ovf[0], 1'b0);

    // Full queue with a write on the pop cycle
    cen_mode = 0;
    for (int k = 0; k < 8; k++) wr_dat(8'(k + 8'h30));
    chk("t3_full_pre", full[0], 1'b1);
    step(1'b1, 2'b01, 8'hAA, 1'b1, 1'b0);
    chk("t3_pop", stb[0], 1'b1);
    chk("t3_full", full[0], 1'b1);
    chk("t3_ovf", ovf[0], 1'b0);
    cen_mode = 1;
    idle(80);

    // OPL3 second bank: NEW bit, then channel 12 F-number low
    wr_sel(1'b1, 8'h05);
    wr_dat(8'h01);
    wr_sel(1'b1, 8'hA3);
    wr_dat(8'h55);
    idle(30);
    chk("t4_opl3_en", o3en[0], 1'b1);
    chk("t4_ch", ch[0], 5'd12);
    chk("t4_grp", grp[0], 2'd1);
    chk("t4_bank", bank[0], 1'b1);
    chk("t4_up", last_up[0], 11'b000_0010_0000);

    // OPL: 0xE0 and 0xB9 are not registers of this chip
    drains[1] = 0;
    up_acc1 = '0;
    wr_sel(1'b0, 8'hE0);
    wr_dat(8'h12);
    wr_sel(1'b0, 8'hB9);
    wr_dat(8'h34);
    idle(30);
    chk("t5_drains", drains[1], 2);
    chk("t5_no_up", up_acc1, 11'd0);
    chk("t5_sel_held", {grp[1], sub[1], ch[1]}, {2'd1, 3'd3, 5'd3});

    // Reset with entries queued
    cen_mode = 0;
    wr_sel(1'b0, 8'hA1);
    for (int k = 0; k < 5; k++) wr_dat(8'(k));
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drains[0] = 0;
    cen_mode = 1;
    idle(30);
    chk("t6_no_drain", drains[0], 0);

    // Randomised traffic
    cen_mode = 2;
    for (int k = 0; k < 1500; k++) begin
      int p;
      logic [7:0] r;
      logic clr;
      p   = int'($urandom % 8);
      clr = ($urandom % 20) == 0;
      r   = (($urandom % 2) == 0) ? picks[$urandom % 12] : 8'($urandom);
      if (p < 2)      step(1'b1, {1'($urandom), 1'b0}, r, next_cen(), clr);
      else if (p < 5) step(1'b1, {1'($urandom), 1'b1}, 8'($urandom), next_cen(), clr);
      else            step(1'b0, 2'b00, 8'h00, next_cen(), clr);
    end
    cen_mode = 1;
    idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
